// File: rtl/fraction_mac_seq.sv
// fraction_mac_seq: sequences 4-bit fraction operand pairs through an external
// fraction_multiplier4, accumulates the 7-bit products with saturation, and
// presents sum / term count / overflow when the term flagged last is folded in.
//
// Handshakes: a transfer happens on a rising CLK edge where valid and ready are
// both 1. A source holds valid and its data until that edge; valid does not
// depend on ready. Here In_Ready and Out_Valid are decoded from the state
// register only, so neither side sees a combinational path through this block.
module fraction_mac_seq #(
  parameter int ACC_W = 10,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             Rst,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [3:0]       In_Mplier,
  input  logic [3:0]       In_Mcand,
  input  logic             In_Last,
  output logic             Mul_St,
  output logic [3:0]       Mul_Mplier,
  output logic [3:0]       Mul_Mcand,
  input  logic [6:0]       Mul_Product,
  input  logic             Mul_Done,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [ACC_W-1:0] Out_Sum,
  output logic [CNT_W-1:0] Out_Count,
  output logic             Out_Ovf,
  output logic [2:0]       Dbg_State
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_ACCUM = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t state, state_next;

  logic [3:0]       mplier_q;
  logic [3:0]       mcand_q;
  logic             last_q;
  logic [6:0]       prod_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic [ACC_W-1:0] sum_o;
  logic [CNT_W-1:0] cnt_o;
  logic             ovf_o;

  // One extra bit of headroom so a signed overflow shows up as the top two
  // bits disagreeing.
  logic [ACC_W:0]   sum_wide;
  logic             add_ovf;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] cnt_next;

  // Saturating add of the sign-extended product and saturating term count.
  always_comb begin
    sum_wide = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-6){prod_q[6]}}, prod_q};
    add_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    acc_next = sum_wide[ACC_W-1:0];
    if (add_ovf) begin
      if (sum_wide[ACC_W]) acc_next = {1'b1, {(ACC_W-1){1'b0}}};
      else                 acc_next = {1'b0, {(ACC_W-1){1'b1}}};
    end
    cnt_next = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  end

  // State register.
  always_ff @(posedge CLK or posedge Rst) begin
    if (Rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state decode; Done is only looked at in WAIT, so a Done level that
  // lingers past its first cycle is ignored.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (In_Valid) state_next = S_START;
      S_START: state_next = S_WAIT;
      S_WAIT:  if (Mul_Done) state_next = S_ACCUM;
      S_ACCUM: state_next = last_q ? S_OUT : S_IDLE;
      S_OUT:   if (Out_Ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Operand capture, product capture, accumulation and result registers.
  always_ff @(posedge CLK or posedge Rst) begin
    if (Rst) begin
      mplier_q <= '0;
      mcand_q  <= '0;
      last_q   <= 1'b0;
      prod_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      sum_o    <= '0;
      cnt_o    <= '0;
      ovf_o    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (In_Valid) begin
            mplier_q <= In_Mplier;
            mcand_q  <= In_Mcand;
            last_q   <= In_Last;
          end
        end
        S_WAIT: begin
          if (Mul_Done) prod_q <= Mul_Product;
        end
        S_ACCUM: begin
          acc_q <= acc_next;
          cnt_q <= cnt_next;
          ovf_q <= ovf_q | add_ovf;
          if (last_q) begin
            sum_o <= acc_next;
            cnt_o <= cnt_next;
            ovf_o <= ovf_q | add_ovf;
          end
        end
        S_OUT: begin
          if (Out_Ready) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Moore outputs; operands go to the multiplier straight from the capture
  // registers so Mcand stays put for the whole multiply.
  always_comb begin
    In_Ready   = (state == S_IDLE) && !Rst;
    Mul_St     = (state == S_START);
    Out_Valid  = (state == S_OUT);
    Mul_Mplier = mplier_q;
    Mul_Mcand  = mcand_q;
    Out_Sum    = sum_o;
    Out_Count  = cnt_o;
    Out_Ovf    = ovf_o;
    Dbg_State  = state;
  end

endmodule

// File: tb/tb_fraction_mac_seq.sv
// tb_fraction_mac_seq: drives two fraction_mac_seq instances (ACC_W=10 and
// ACC_W=8) in lockstep from one stream, with a behavioural multiplier that
// answers Mul_St after a variable latency.
module tb_fraction_mac_seq;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic Rst;
  always #5 CLK = ~CLK;

  logic       In_Valid, In_Last, Out_Ready;
  logic [3:0] In_Mplier, In_Mcand;
  logic [6:0] Mul_Product = '0;
  logic       Mul_Done = 1'b0;

  logic       in_ready, mul_st, out_valid, out_ovf;
  logic [3:0] mul_mplier, mul_mcand, out_count;
  logic [9:0] out_sum;
  logic [2:0] dbg_state;

  logic       in_ready8, mul_st8, out_valid8, out_ovf8;
  logic [3:0] mul_mplier8, mul_mcand8, out_count8;
  logic [7:0] out_sum8;
  logic [2:0] dbg_state8;

  fraction_mac_seq #(.ACC_W(10), .CNT_W(4)) dut (
    .CLK(CLK), .Rst(Rst), .In_Valid(In_Valid), .In_Ready(in_ready),
    .In_Mplier(In_Mplier), .In_Mcand(In_Mcand), .In_Last(In_Last),
    .Mul_St(mul_st), .Mul_Mplier(mul_mplier), .Mul_Mcand(mul_mcand),
    .Mul_Product(Mul_Product), .Mul_Done(Mul_Done),
    .Out_Valid(out_valid), .Out_Ready(Out_Ready), .Out_Sum(out_sum),
    .Out_Count(out_count), .Out_Ovf(out_ovf), .Dbg_State(dbg_state)
  );

  fraction_mac_seq #(.ACC_W(8), .CNT_W(4)) dut8 (
    .CLK(CLK), .Rst(Rst), .In_Valid(In_Valid), .In_Ready(in_ready8),
    .In_Mplier(In_Mplier), .In_Mcand(In_Mcand), .In_Last(In_Last),
    .Mul_St(mul_st8), .Mul_Mplier(mul_mplier8), .Mul_Mcand(mul_mcand8),
    .Mul_Product(Mul_Product), .Mul_Done(Mul_Done),
    .Out_Valid(out_valid8), .Out_Ready(Out_Ready), .Out_Sum(out_sum8),
    .Out_Count(out_count8), .Out_Ovf(out_ovf8), .Dbg_State(dbg_state8)
  );

  // ---------------- scoreboard state ----------------
  int compared = 0;
  int mismatched = 0;
  logic [14:0] exp_q[$];    // {ovf, count, sum10}
  logic [12:0] exp8_q[$];   // {ovf, count, sum8}
  logic [7:0]  op_q[$];     // {mplier, mcand} in issue order
  int acc10 = 0, acc8 = 0, cnt = 0;
  bit ovf10 = 0, ovf8 = 0;
  int st_seen = 0, terms_sent = 0;
  int force_lat = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int prod_of(input logic [7:0] op);
    int a, b;
    a = $signed(op[7:4]);
    b = $signed(op[3:0]);
    return a * b;
  endfunction

  function automatic int sat_add(input int a, input int p, input int w, output bit ovf);
    int mx, mn, s;
    mx = (1 << (w - 1)) - 1;
    mn = -(1 << (w - 1));
    s = a + p;
    ovf = 1'b0;
    if (s > mx) begin s = mx; ovf = 1'b1; end
    else if (s < mn) begin s = mn; ovf = 1'b1; end
    return s;
  endfunction

  // ---------------- multiplier model ----------------
  logic [7:0] cur_op;
  int lat, hold;
  bit busy = 0, post = 0;
  always @(negedge CLK) begin
    logic [31:0] p;
    if (Rst) begin
      busy = 0; post = 0; hold = 0; Mul_Done = 1'b0;
    end else begin
      check("st_pair", {mul_st8, in_ready8}, {mul_st, in_ready});
      if (mul_st) begin
        st_seen++;
        check("st_while_busy", busy, 1'b0);
        check("st_has_op", op_q.size() > 0, 1'b1);
        if (op_q.size() > 0) cur_op = op_q.pop_front();
        check("st_operands", {mul_mplier, mul_mcand}, cur_op);
        lat = (force_lat >= 0) ? force_lat : $urandom_range(0, 3);
        Mul_Done = 1'b0; busy = 1; post = 0;
      end else if (busy) begin
        check("wait_operands", {mul_mplier, mul_mcand}, cur_op);
        if (lat == 0) begin
          p = prod_of(cur_op);
          Mul_Product = p[6:0];
          Mul_Done = 1'b1; busy = 0; post = 1;
          hold = $urandom_range(1, 2);
        end else begin
          lat--;
        end
      end else begin
        if (post) begin
          check("accum_operands", {mul_mplier, mul_mcand}, cur_op);
          post = 0;
        end
        if (Mul_Done) begin
          hold--;
          if (hold <= 0) Mul_Done = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [3:0] mp, input logic [3:0] mc, input logic last);
    int w, p;
    bit o;
    w = 0;
    @(negedge CLK);
    while (!in_ready && w < 200) begin @(negedge CLK); w++; end
    check("in_ready_before_send", in_ready, 1'b1);
    In_Valid = 1'b1; In_Mplier = mp; In_Mcand = mc; In_Last = last;
    op_q.push_back({mp, mc});
    terms_sent++;
    p = prod_of({mp, mc});
    acc10 = sat_add(acc10, p, 10, o); ovf10 |= o;
    acc8  = sat_add(acc8,  p, 8,  o); ovf8  |= o;
    if (cnt < 15) cnt++;
    if (last) begin
      exp_q.push_back({ovf10, cnt[3:0], acc10[9:0]});
      exp8_q.push_back({ovf8, cnt[3:0], acc8[7:0]});
      acc10 = 0; acc8 = 0; cnt = 0; ovf10 = 0; ovf8 = 0;
    end
    @(negedge CLK);
    In_Valid = 1'b0;
  endtask

  task automatic collect(input string tag);
    logic [14:0] e10;
    logic [12:0] e8;
    int w;
    w = 0;
    while (!out_valid && w < 300) begin @(negedge CLK); w++; end
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_have_exp"}, exp_q.size() > 0, 1'b1);
    e10 = exp_q.pop_front();
    e8  = exp8_q.pop_front();
    check({tag, "_res10"}, {out_ovf, out_count, out_sum}, e10);
    check({tag, "_res8"}, {out_ovf8, out_count8, out_sum8}, e8);
    check({tag, "_in_ready_out"}, in_ready, 1'b0);
    check({tag, "_st_count"}, st_seen, terms_sent);
    @(negedge CLK);
    check({tag, "_valid_drop"}, out_valid, 1'b0);
    check({tag, "_sum_held"}, out_sum, e10[9:0]);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [14:0] bp_exp;
    int w, st_before, n;
    logic [3:0] a, b;

    Rst = 1'b1; In_Valid = 1'b0; In_Mplier = '0; In_Mcand = '0; In_Last = 1'b0;
    Out_Ready = 1'b1;
    repeat (2) @(negedge CLK);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_mul_st", mul_st, 1'b0);
    check("rst_outputs", {out_ovf, out_count, out_sum}, 15'h0);
    #2 Rst = 1'b0;
    @(negedge CLK);
    check("idle_in_ready", in_ready, 1'b1);

    // single term 0.5 x 0.5
    send(4'b0100, 4'b0100, 1'b1);
    collect("half_sq");

    // (-0.5) x 0.5
    send(4'b1100, 4'b0100, 1'b1);
    collect("neg_term");

    // three terms of 0.25
    repeat (2) send(4'b0100, 4'b0100, 1'b0);
    send(4'b0100, 4'b0100, 1'b1);
    collect("three_terms");

    // eight x 0.765625: saturates at 8 bits, fits at 10 bits
    repeat (7) send(4'b0111, 4'b0111, 1'b0);
    send(4'b0111, 4'b0111, 1'b1);
    collect("pos_sat");

    // eight x -0.765625: negative saturation at 8 bits
    repeat (7) send(4'b1001, 4'b0111, 1'b0);
    send(4'b1001, 4'b0111, 1'b1);
    collect("neg_sat");

    // sixteen smallest products: count stops at 15
    repeat (15) send(4'b0001, 4'b0001, 1'b0);
    send(4'b0001, 4'b0001, 1'b1);
    collect("cnt_sat");

    // random sums
    for (int s = 0; s < 4; s++) begin
      n = $urandom_range(1, 5);
      for (int t = 0; t < n; t++) begin
        a = 4'($urandom_range(0, 15));
        b = 4'($urandom_range(0, 15));
        if (a == 4'b1000 && b == 4'b1000) b = 4'b0000;
        send(a, b, (t == n - 1));
      end
      collect("random");
    end

    // backpressure in OUT
    Out_Ready = 1'b0;
    send(4'b0100, 4'b0100, 1'b1);
    w = 0;
    while (!out_valid && w < 300) begin @(negedge CLK); w++; end
    bp_exp = exp_q[0];
    In_Valid = 1'b1; In_Mplier = 4'b0111; In_Mcand = 4'b0111; In_Last = 1'b1;
    st_before = st_seen;
    repeat (5) begin
      @(negedge CLK);
      check("bp_valid", out_valid, 1'b1);
      check("bp_sum", {out_ovf, out_count, out_sum}, bp_exp);
      check("bp_in_ready", in_ready, 1'b0);
    end
    check("bp_no_st", st_seen, st_before);
    In_Valid = 1'b0;
    Out_Ready = 1'b1;
    collect("bp");
    send(4'b0100, 4'b0100, 1'b1);
    collect("after_bp");

    // reset while waiting on the multiplier
    force_lat = 10;
    send(4'b0100, 4'b0100, 1'b0);
    repeat (3) @(negedge CLK);
    check("wait_in_ready", in_ready, 1'b0);
    #2 Rst = 1'b1;
    #1;
    check("arst_in_ready", in_ready, 1'b0);
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_mul_st", mul_st, 1'b0);
    check("arst_outputs", {out_ovf, out_count, out_sum}, 15'h0);
    op_q.delete();
    acc10 = 0; acc8 = 0; cnt = 0; ovf10 = 0; ovf8 = 0;
    st_seen = 0; terms_sent = 0; force_lat = -1;
    repeat (2) @(negedge CLK);
    #2 Rst = 1'b0;
    send(4'b0100, 4'b0100, 1'b1);
    collect("post_rst");

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Time limit so a stuck design still ends the run.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "time limit reached");
  end

endmodule
